gcd_engine: RTL and testbench

Parametrised successor to the fixed-width HCF controller/datapath pair. A single block computes the GCD (HCF) of two WIDTH-bit unsigned operands, selectable per request between subtractive Euclid and binary (Stein) algorithms. It uses valid/ready handshakes on input and output, an iteration counter, a configurable timeout with error flag, defined zero-operand handling, and a synchronous abort. It sits between an operand producer and a result consumer on one clock domain.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_step_dp.sv | 59 +++++
 rtl/gcd_engine.sv | 141 ++++++++++++++
 tb/tb_gcd_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine.
//   state_t    : engine FSM states
//   MODE_SUB   : subtractive Euclid select value for in_mode
//   MODE_STEIN : binary (Stein) select value for in_mode
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SUB   = 3'd2,
    STEIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic MODE_SUB   = 1'b0;
  localparam logic MODE_STEIN = 1'b1;

endpackage : gcd_pkg

// File: rtl/gcd_step_dp.sv
// One combinational reduction step of the GCD datapath.
//   a, b, k      : current operand pair and common power-of-two shift
//   mode         : MODE_SUB or MODE_STEIN
//   a_nxt, b_nxt : operands after one step
//   k_nxt        : shift count after one step
//   eq           : a == b (terminal condition)
//   zero         : either operand is zero
module gcd_step_dp
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K_W   = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [K_W-1:0]   k,
  input  logic             mode,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [K_W-1:0]   k_nxt,
  output logic             eq,
  output logic             zero
);

  assign eq   = (a == b);
  assign zero = (a == '0) || (b == '0);

  // Reduce the larger operand, or halve even operands in binary mode.
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_nxt = k;
    if (mode == MODE_SUB) begin
      if (a > b) begin
        a_nxt = a - b;
      end else if (b > a) begin
        b_nxt = b - a;
      end
    end else begin
      unique case ({a[0], b[0]})
        2'b00: begin
          a_nxt = a >> 1;
          b_nxt = b >> 1;
          k_nxt = k + K_W'(1);
        end
        2'b01: a_nxt = a >> 1;
        2'b10: b_nxt = b >> 1;
        default: begin
          if (a > b) begin
            a_nxt = a - b;
          end else if (b > a) begin
            b_nxt = b - a;
          end
        end
      endcase
    end
  end

endmodule : gcd_step_dp

// File: rtl/gcd_engine.sv
// GCD engine: subtractive Euclid or binary Stein, selectable per request,
// with valid/ready handshakes, iteration count, timeout and abort.
//   clk, rst_n          : clock, async active-low reset
//   abort               : synchronous abort back to IDLE, no result delivered
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_mode)
//   out_valid/out_ready : result handshake (out_gcd, out_iter, out_err)
//   busy                : engine is not IDLE
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ITER_W   = 16,
  parameter int unsigned MAX_ITER = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_gcd,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned     K_W        = $clog2(WIDTH) + 1;
  localparam logic [ITER_W-1:0] ITER_SAT   = '1;
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam bit              TIMEOUT_EN = (MAX_ITER != 0);

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [K_W-1:0]    k_q;
  logic [ITER_W-1:0] iter_q;
  logic              mode_q;

  logic [WIDTH-1:0]  a_nxt;
  logic [WIDTH-1:0]  b_nxt;
  logic [K_W-1:0]    k_nxt;
  logic              eq;
  logic              zero;

  assign in_ready = (state == IDLE) && !abort;
  assign busy     = (state != IDLE);

  gcd_step_dp #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_step (
    .a     (a_q),
    .b     (b_q),
    .k     (k_q),
    .mode  (mode_q),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .k_nxt (k_nxt),
    .eq    (eq),
    .zero  (zero)
  );

  // Control FSM, operand registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      iter_q    <= '0;
      mode_q    <= MODE_SUB;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_iter  <= '0;
      out_err   <= 1'b0;
    end else if (abort) begin
      // Abort wins over accept and over the output handshake.
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= in_a;
            b_q    <= in_b;
            mode_q <= in_mode;
            k_q    <= '0;
            iter_q <= '0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (zero) begin
            out_gcd  <= a_q | b_q;
            out_iter <= iter_q;
            out_err  <= 1'b0;
            state    <= DONE;
          end else begin
            state <= (mode_q == MODE_STEIN) ? STEIN : SUB;
          end
        end
        SUB, STEIN: begin
          if (eq) begin
            // k is always zero in subtractive mode, so one path serves both.
            out_gcd  <= a_q << k_q;
            out_iter <= iter_q;
            out_err  <= 1'b0;
            state    <= DONE;
          end else if (TIMEOUT_EN && (iter_q == ITER_LIMIT)) begin
            out_gcd  <= '0;
            out_iter <= iter_q;
            out_err  <= 1'b1;
            state    <= DONE;
          end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
            k_q <= k_nxt;
            if (iter_q != ITER_SAT) begin
              iter_q <= iter_q + ITER_W'(1);
            end
          end
        end
        DONE: begin
          // First DONE cycle raises out_valid; hold until the consumer takes it.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed corner cases plus randomized
// requests checked against a behavioural reference model.
module tb_gcd_engine;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned ITER_W   = 16;
  localparam int unsigned MAX_ITER = 1023;

  logic              clk;
  logic              rst_n;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_gcd;
  logic [ITER_W-1:0] out_iter;
  logic              out_err;
  logic              busy;

  int unsigned n_tests;
  int unsigned n_fail;

  gcd_engine #(
    .WIDTH    (WIDTH),
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_iter  (out_iter),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Golden GCD by remainder Euclid.
  function automatic int unsigned gcd_mod(input int unsigned a, input int unsigned b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Expected result: step count from the algorithm rules, value from gcd_mod.
  function automatic void ref_model(input int unsigned a0, input int unsigned b0, input bit mode,
                                    output int unsigned g, output int unsigned it, output bit err);
    int unsigned a = a0;
    int unsigned b = b0;
    it  = 0;
    err = 1'b0;
    g   = a0 | b0;
    if (a0 == 0 || b0 == 0) return;
    while (a != b) begin
      if (MAX_ITER != 0 && it == MAX_ITER) begin
        err = 1'b1;
        g   = 0;
        return;
      end
      if (!mode) begin
        if (a > b) a = a - b; else b = b - a;
      end else if (a % 2 == 0 && b % 2 == 0) begin
        a = a / 2;
        b = b / 2;
      end else if (a % 2 == 0) begin
        a = a / 2;
      end else if (b % 2 == 0) begin
        b = b / 2;
      end else if (a > b) begin
        a = a - b;
      end else begin
        b = b - a;
      end
      it++;
    end
    g = gcd_mod(a0, b0);
  endfunction

  // Wait for in_ready, present one request, accept on the next rising edge.
  task automatic send(input int unsigned a, input int unsigned b, input bit mode);
    int unsigned n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    in_mode  = mode;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_mode  = ~mode;
  endtask

  // Edges after accept until out_valid is observed; bounded.
  task automatic wait_valid(output int unsigned lat);
    lat = 0;
    while (!out_valid && lat < 3000) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Full transaction with out_ready high, checking every result field.
  task automatic run_txn(input int unsigned a, input int unsigned b, input bit mode);
    int unsigned eg, ei, lat, elat;
    bit ee;
    ref_model(a, b, mode, eg, ei, ee);
    elat = (a == 0 || b == 0) ? 2 : 3 + ei;
    send(a, b, mode);
    wait_valid(lat);
    check("out_valid", 32'(out_valid), 32'd1);
    check("latency", lat, elat);
    check("out_gcd", 32'(out_gcd), eg);
    check("out_iter", 32'(out_iter), ei);
    check("out_err", 32'(out_err), 32'(ee));
    check("in_ready_done", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("out_valid_clr", 32'(out_valid), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int unsigned lat;
    int unsigned hi_cnt;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_gcd", 32'(out_gcd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the algorithm description.
    run_txn(48, 18, 1'b0);
    run_txn(48, 18, 1'b1);
    run_txn(1024, 64, 1'b1);
    run_txn(0, 35, 1'b0);
    run_txn(0, 35, 1'b1);
    run_txn(0, 0, 1'b1);
    run_txn(65535, 1, 1'b0);

    // Abort two cycles into SUB; out_err must keep the timeout flag.
    send(100, 7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_err", 32'(out_err), 32'd1);
    abort = 1'b0;
    #1;
    check("abort_in_ready_rel", 32'(in_ready), 32'd1);
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) hi_cnt++;
    end
    check("abort_quiet", hi_cnt, 32'd0);

    run_txn(65535, 1, 1'b1);

    // Back-pressure: result held, extra request ignored.
    out_ready = 1'b0;
    send(48, 18, 1'b1);
    wait_valid(lat);
    check("bp_latency", lat, 32'd9);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_gcd", 32'(out_gcd), 32'd6);
      check("bp_iter", 32'(out_iter), 32'd6);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (busy) hi_cnt++;
    end
    check("bp_no_accept", hi_cnt, 32'd0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 30; i++) begin
      int unsigned ra, rb, sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        ra = $urandom_range(0, 20);
        rb = $urandom_range(0, 20);
      end else if (sel == 3) begin
        ra = $urandom_range(0, 65535);
        rb = $urandom_range(1, 65535);
      end else begin
        ra = $urandom_range(1, 2000);
        rb = $urandom_range(1, 2000);
      end
      run_txn(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a computation.
    run_txn(48, 18, 1'b0);
    send(100, 7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_gcd", 32'(out_gcd), 32'd0);
    check("mid_rst_iter", 32'(out_iter), 32'd0);
    check("mid_rst_err", 32'(out_err), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(21, 14, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gcd_engine
